// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame receiver.
// The FSM state type and the parity helper live here so sub-blocks agree on them.
package serial_frame_pkg;

    localparam int DEFAULT_DATA_W    = 8;
    localparam bit DEFAULT_PARITY_EN = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Even-parity bit of a word up to 16 bits; narrower words are zero-extended.
    function automatic logic evenParity(input logic [15:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/rx_shift_reg.sv
// Serial-in parallel-out capture register for the receiver's data bits.
// Bits arrive LSB first, so each new bit enters at the top and moves down.
module rx_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_shiftEn,
    input  logic             i_serial,
    output logic [WIDTH-1:0] o_word
);

    logic [WIDTH-1:0] r_word;

    // After WIDTH shifts the first bit received sits in bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
        end else if (i_clear) begin
            r_word <= '0;
        end else if (i_shiftEn) begin
            r_word <= {i_serial, r_word[WIDTH-1:1]};
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional even parity, stop bit.
// One bit per clock; event outputs are registered one-cycle pulses.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter bit PARITY_EN = DEFAULT_PARITY_EN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_bitCnt;
    logic               r_parityFlag;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_parityErr;
    logic               r_frameErr;
    logic [7:0]         r_frameCnt;

    logic [DATA_W-1:0]  w_word;
    logic               w_lastBit;
    logic               w_parityMismatch;
    logic               w_clear;
    logic               w_shiftEn;
    logic               w_parityCheck;
    logic               w_frameGood;
    logic               w_frameBad;

    assign w_lastBit        = (r_bitCnt == LAST_BIT);
    assign w_parityMismatch = din ^ evenParity(16'(w_word));

    rx_shift_reg #(
        .WIDTH (DATA_W)
    ) u_shiftReg (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_shiftEn (w_shiftEn),
        .i_serial  (din),
        .o_word    (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (!din) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_lastBit) begin
                    if (PARITY_EN) begin
                        w_nextState = PARITY;
                    end else begin
                        w_nextState = STOP;
                    end
                end
            end
            PARITY: w_nextState = STOP;
            // A zero stop bit returns to IDLE without being read as a new start bit.
            STOP:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_clear       = 1'b0;
        w_shiftEn     = 1'b0;
        w_parityCheck = 1'b0;
        w_frameGood   = 1'b0;
        w_frameBad    = 1'b0;
        case (r_state)
            IDLE:    w_clear       = ~din;
            DATA:    w_shiftEn     = 1'b1;
            PARITY:  w_parityCheck = 1'b1;
            STOP: begin
                w_frameGood = din;
                w_frameBad  = ~din;
            end
            default: w_clear = 1'b0;
        endcase
    end

    // Bit counter and parity flag restart with every accepted start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitCnt     <= '0;
            r_parityFlag <= 1'b0;
        end else if (w_clear) begin
            r_bitCnt     <= '0;
            r_parityFlag <= 1'b0;
        end else begin
            if (w_shiftEn) begin
                r_bitCnt <= r_bitCnt + CNT_W'(1);
            end
            if (w_parityCheck && w_parityMismatch) begin
                r_parityFlag <= 1'b1;
            end
        end
    end

    // Bad parity still delivers the word and counts the frame; only a bad stop is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;
            r_frameCnt  <= 8'd0;
        end else begin
            r_valid     <= w_frameGood;
            r_parityErr <= w_frameGood & r_parityFlag;
            r_frameErr  <= w_frameBad;
            if (w_frameGood) begin
                r_data     <= w_word;
                r_frameCnt <= r_frameCnt + 8'd1;
            end
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_parityErr;
    assign frame_err  = r_frameErr;
    assign busy       = (r_state != IDLE);
    assign frame_cnt  = r_frameCnt;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus random traffic against a frame-level model.
// A second instance covers the build without a parity bit.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] frame_cnt;

    logic       rstB;
    logic       dinB;
    logic [7:0] dataB;
    logic       validB;
    logic       parityErrB;
    logic       frameErrB;
    logic       busyB;
    logic [7:0] frameCntB;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int lastValidCycle = 0;
    int firstValidCycle = 0;

    logic [7:0] expData;
    logic [7:0] expCnt;
    logic [7:0] expDataB;
    logic [7:0] expCntB;

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    serial_frame_rx u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    serial_frame_rx #(
        .DATA_W    (8),
        .PARITY_EN (1'b0)
    ) u_dutNoPar (
        .clk        (clk),
        .rst        (rstB),
        .din        (dinB),
        .data       (dataB),
        .valid      (validB),
        .parity_err (parityErrB),
        .frame_err  (frameErrB),
        .busy       (busyB),
        .frame_cnt  (frameCntB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sendBit(input logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic sendBitB(input logic b);
        dinB = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        sendBit(1'b1);
        checkOutput("idle_valid", valid, 1'b0);
        checkOutput("idle_frame_err", frame_err, 1'b0);
        checkOutput("idle_busy", busy, 1'b0);
    endtask

    // Sends one frame on the parity-enabled instance and checks it against the frame model.
    task automatic applyStimulus(input logic [7:0] w, input logic p, input logic s);
        logic expPe;
        sendBit(1'b0);
        checkOutput("start_busy", busy, 1'b1);
        checkOutput("start_valid", valid, 1'b0);
        checkOutput("start_frame_err", frame_err, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sendBit(w[i]);
            checkOutput("data_valid_early", valid, 1'b0);
        end
        sendBit(p);
        checkOutput("parity_valid_early", valid, 1'b0);
        sendBit(s);
        expPe = s && (p != (^w));
        if (s) begin
            expData = w;
            expCnt  = expCnt + 8'd1;
        end
        if (valid === 1'b1) lastValidCycle = cycle;
        checkOutput("stop_valid", valid, s);
        checkOutput("stop_parity_err", parity_err, expPe);
        checkOutput("stop_frame_err", frame_err, !s);
        checkOutput("stop_data", data, expData);
        checkOutput("stop_frame_cnt", frame_cnt, expCnt);
        checkOutput("stop_busy", busy, 1'b0);
    endtask

    task automatic applyStimulusB(input logic [7:0] w, input logic s);
        sendBitB(1'b0);
        checkOutput("B_start_busy", busyB, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sendBitB(w[i]);
            checkOutput("B_valid_early", validB, 1'b0);
        end
        sendBitB(s);
        if (s) begin
            expDataB = w;
            expCntB  = expCntB + 8'd1;
        end
        checkOutput("B_stop_valid", validB, s);
        checkOutput("B_stop_parity_err", parityErrB, 1'b0);
        checkOutput("B_stop_frame_err", frameErrB, !s);
        checkOutput("B_stop_data", dataB, expDataB);
        checkOutput("B_stop_frame_cnt", frameCntB, expCntB);
        sendBitB(1'b1);
        checkOutput("B_idle_valid", validB, 1'b0);
    endtask

    initial begin
        logic [7:0] w;
        logic       p;
        logic       s;

        din  = 1'b1;
        dinB = 1'b1;
        rst  = 1'b1;
        rstB = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_valid", valid, 1'b0);
        checkOutput("reset_parity_err", parity_err, 1'b0);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_frame_cnt", frame_cnt, 8'd0);
        rst     = 1'b0;
        rstB    = 1'b0;
        expData = 8'h00;
        expCnt  = 8'd0;
        expDataB = 8'h00;
        expCntB  = 8'd0;
        idleCycle();
        idleCycle();

        // Good frame, then same word with wrong parity
        applyStimulus(8'hA5, 1'b0, 1'b1);
        idleCycle();
        checkOutput("pulse_parity_err", parity_err, 1'b0);
        applyStimulus(8'hA5, 1'b1, 1'b1);
        idleCycle();
        checkOutput("pulse_parity_err2", parity_err, 1'b0);

        // Stop bit of zero: frame error, data held, zero not treated as start
        applyStimulus(8'h3C, 1'b0, 1'b0);
        idleCycle();

        // Back-to-back frames with no gap
        applyStimulus(8'h01, 1'b1, 1'b1);
        firstValidCycle = lastValidCycle;
        applyStimulus(8'hFF, 1'b0, 1'b1);
        checkOutput("b2b_spacing", lastValidCycle - firstValidCycle, 11);
        idleCycle();

        // Reset in the middle of a frame
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        din = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        expData = 8'h00;
        expCnt  = 8'd0;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_data", data, 8'h00);
        checkOutput("midrst_frame_cnt", frame_cnt, 8'd0);
        repeat (12) idleCycle();
        applyStimulus(8'h5A, 1'b0, 1'b1);
        idleCycle();

        // 256 good frames wrap the counter back to where it started
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        expData = 8'h00;
        expCnt  = 8'd0;
        for (int n = 0; n < 256; n++) begin
            w = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            applyStimulus(w, p, 1'b1);
        end
        checkOutput("wrap_frame_cnt", frame_cnt, 8'd0);

        // Random traffic: mostly good stops, random gaps
        for (int n = 0; n < 60; n++) begin
            w = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0);
            applyStimulus(w, p, s);
            repeat ($urandom_range(0, 2)) idleCycle();
        end
        idleCycle();

        // Parity-less build: 10-bit frame, valid nine edges after the start edge
        applyStimulusB(8'hA5, 1'b1);
        applyStimulusB(8'h3C, 1'b0);
        applyStimulusB(8'h96, 1'b1);
        checkOutput("B_final_busy", busyB, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
